// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for the multdiv path.
// Produces one quotient bit per clock on a 2*WIDTH-bit remainder/quotient
// register. The register shifts left each step and the divisor is
// trial-subtracted from its upper part.
// A start/busy/ready handshake faces the pipeline stall logic.
// div_by_zero feeds the exception path.
// Optional feature macro: DIV_SIGNED_EN. When it is defined, operands are
// signed two's-complement (truncating division). When it is undefined,
// operands are unsigned.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    // Upper half holds the partial remainder.
    // Lower half holds the dividend bits still to be consumed and the
    // quotient bits produced so far.
    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] work_step;
    logic [WIDTH:0]     div_mag;
    logic [WIDTH:0]     trial;
    logic [CW-1:0]      count;

    // A zero divisor was accepted.
    // The exception result is posted one edge later.
    logic               zero_pend;

    logic               accept;
    logic               divisor_zero;
    logic               last_iter;
    logic [WIDTH:0]     dividend_mag;
    logic [WIDTH:0]     divisor_mag;
    logic [WIDTH:0]     load_val;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

`ifdef DIV_SIGNED_EN
    logic               neg_quot;
    logic               neg_rem;
    logic [WIDTH:0]     dividend_ext;
    logic [WIDTH:0]     divisor_ext;
`endif

    assign divisor_zero = (divisor == '0);
    assign accept       = start && (state != RUN) && !zero_pend;
    assign last_iter    = (state == RUN) && (count == LAST);
    assign busy         = (state == RUN);
    assign ready        = (state == DONE);

`ifdef DIV_SIGNED_EN
    // Take magnitudes in WIDTH+1 bits so the most-negative operand cannot overflow.
    always_comb begin
        dividend_ext = {dividend[WIDTH-1], dividend};
        divisor_ext  = {divisor[WIDTH-1], divisor};
        dividend_mag = dividend_ext;
        divisor_mag  = divisor_ext;
        if (dividend[WIDTH-1]) begin
            dividend_mag = -dividend_ext;
        end
        if (divisor[WIDTH-1]) begin
            divisor_mag = -divisor_ext;
        end
    end
`else
    // Unsigned operands are their own magnitudes.
    always_comb begin
        dividend_mag = {1'b0, dividend};
        divisor_mag  = {1'b0, divisor};
    end
`endif

    // A zero divisor keeps the raw dividend so it can be returned as the remainder.
    always_comb begin
        load_val = dividend_mag;
        if (divisor_zero) begin
            load_val = {1'b0, dividend};
        end
    end

    // One restoring step: shift left, then trial-subtract the divisor from the upper WIDTH+1 bits.
    always_comb begin
        trial     = work[2*WIDTH-1:WIDTH-1] - div_mag;
        work_step = {work[2*WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            work_step = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up on the final step's result.
    always_comb begin
        q_fix = work_step[WIDTH-1:0];
        r_fix = work_step[2*WIDTH-1:WIDTH];
`ifdef DIV_SIGNED_EN
        if (neg_quot) begin
            q_fix = ~work_step[WIDTH-1:0] + 1'b1;
        end
        if (neg_rem) begin
            r_fix = ~work_step[2*WIDTH-1:WIDTH] + 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A zero divisor parks in IDLE for one edge, then reports from DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (zero_pend) begin
                    state_next = DONE;
                end else if (accept) begin
                    state_next = divisor_zero ? IDLE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = divisor_zero ? IDLE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, iterate while running, publish results on completion.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            work        <= '0;
            div_mag     <= '0;
            count       <= '0;
            zero_pend   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else if (accept) begin
            work        <= {{(WIDTH-1){1'b0}}, load_val};
            div_mag     <= divisor_mag;
            count       <= '0;
            zero_pend   <= divisor_zero;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem     <= dividend[WIDTH-1];
`endif
        end else if (state == RUN) begin
            work  <= work_step;
            count <= count + 1'b1;
            if (last_iter) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end else if (zero_pend) begin
            zero_pend   <= 1'b0;
            quotient    <= '1;
            remainder   <= work[WIDTH-1:0];
            div_by_zero <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH=32).
// Expected values follow DIV_SIGNED_EN when the macro is defined.
// Otherwise they follow the unsigned build.
module tb_seq_divider;

    localparam int WIDTH = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  dividend = '0;
    logic [WIDTH-1:0]  divisor = '0;
    logic [WIDTH-1:0]  quotient;
    logic [WIDTH-1:0]  remainder;
    logic              busy;
    logic              ready;
    logic              div_by_zero;

    exp_t sb[$];
    int   cycle = 0;
    int   n_compared = 0;
    int   n_mismatch = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter used to time the ready pulse.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clr_n && ready) begin
            if (sb.size() == 0) begin
                check_output("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("ready_cycle", cycle, e.cyc);
                check_output("quotient", quotient, e.q);
                check_output("remainder", remainder, e.r);
                check_output("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
            end
        end
    end

    // Drive one start.
    // The expected result (signed or unsigned per build) goes to the scoreboard.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] sq, input logic [31:0] sr,
                                  input logic [31:0] uq, input logic [31:0] ur,
                                  input logic dbz);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q   = SIGNED_BUILD ? sq : uq;
        e.r   = SIGNED_BUILD ? sr : ur;
        e.dbz = dbz;
        e.cyc = cycle + ((b == 32'd0) ? 1 : WIDTH);
        sb.push_back(e);
        check_output("busy_after_accept", {31'b0, busy}, {31'b0, (b != 32'd0)});
    endtask

    // Wait (bounded) for the scoreboard to empty.
    task automatic wait_drain();
        for (int i = 0; i < WIDTH + 10; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check_output("drain_outstanding", sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        bit got;
        #3;
        check_output("reset_quotient", quotient, 32'd0);
        check_output("reset_remainder", remainder, 32'd0);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_ready", {31'b0, ready}, 32'd0);
        check_output("reset_dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // Basic and sign combinations.
        apply_stimulus(32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 32'd2, 1'b0);
        wait_drain();
        apply_stimulus(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 32'h24924916, 32'd2, 1'b0);
        wait_drain();
        apply_stimulus(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 32'd0, 32'd100, 1'b0);
        wait_drain();
        apply_stimulus(32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 32'd0, 32'hFFFFFF9C, 1'b0);
        wait_drain();
        apply_stimulus(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd0, 32'h80000000, 1'b0);
        wait_drain();
        apply_stimulus(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd1, 1'b0);
        wait_drain();
        apply_stimulus(32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 1'b0);
        wait_drain();
        apply_stimulus(32'd7, 32'd100, 32'd0, 32'd7, 32'd0, 32'd7, 1'b0);
        wait_drain();

        // Divide by zero, then a normal divide that clears the flag.
        apply_stimulus(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5, 1'b1);
        wait_drain();
        apply_stimulus(32'd6, 32'd3, 32'd2, 32'd0, 32'd2, 32'd0, 1'b0);
        wait_drain();
        apply_stimulus(32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        wait_drain();

        // Start held high with new operands throughout RUN: it must be ignored.
        apply_stimulus(32'd1000, 32'd10, 32'd100, 32'd0, 32'd100, 32'd0, 1'b0);
        dividend = 32'd77;
        divisor  = 32'd5;
        start    = 1'b1;
        repeat (WIDTH - 2) @(negedge clk);
        start = 1'b0;
        check_output("busy_while_held", {31'b0, busy}, 32'd1);
        wait_drain();

        // Start during the ready cycle: back-to-back operations.
        apply_stimulus(32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 32'd2, 1'b0);
        got = 1'b0;
        for (int i = 0; i < WIDTH + 5; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        check_output("b2b_first_ready", {31'b0, got}, 32'd1);
        apply_stimulus(32'd9, 32'd4, 32'd2, 32'd1, 32'd2, 32'd1, 1'b0);
        wait_drain();

        // Asynchronous reset in the middle of RUN aborts without a ready pulse.
        apply_stimulus(32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 32'd2, 1'b0);
        repeat (11) @(negedge clk);
        check_output("busy_before_abort", {31'b0, busy}, 32'd1);
        clr_n = 1'b0;
        #1;
        sb.delete();
        check_output("abort_quotient", quotient, 32'd0);
        check_output("abort_remainder", remainder, 32'd0);
        check_output("abort_busy", {31'b0, busy}, 32'd0);
        check_output("abort_ready", {31'b0, ready}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (WIDTH + 4) @(negedge clk);
        apply_stimulus(32'd9, 32'd4, 32'd2, 32'd1, 32'd2, 32'd1, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
